// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: button conditioning, mode FSM, count-tick prescaler
// and the counter reset / display-freeze strobes for the BCD digit chain.
module stopwatch_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int DEBOUNCE_LEN = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start_stop,
    input  logic btn_lap,
    input  logic btn_clear,
    output logic cnt_enable,
    output logic cnt_reset,
    output logic disp_load,
    output logic running,
    output logic lap_active
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;

    typedef enum logic [1:0] {IDLE, RUN, LAP_RUN, PAUSE} state_t;

    // Button index: 0 = lap, 1 = start/stop, 2 = clear
    logic [2:0]    btn_raw;
    logic [2:0]    sync1, sync2, level, level_q, armed, press;
    logic [DW-1:0] db_cnt [3];
    logic [1:0]    warm;

    state_t        state, state_next;
    logic          clr_accept;
    logic          sel_clr, sel_ss, sel_lap;
    logic [PW-1:0] prescaler;
    logic          rst_q;

    assign btn_raw = {btn_clear, btn_start_stop, btn_lap};

    // A button is armed only once it has been seen released after reset, so a
    // button held through reset never produces a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm    <= '0;
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            armed   <= '0;
            press   <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            warm    <= {warm[0], 1'b1};
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_q <= level;
            press   <= level & ~level_q & armed;
            for (int i = 0; i < 3; i++) begin
                if (warm[1] && !sync2[i] && !level[i]) armed[i] <= 1'b1;
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_LEN - 1)) begin
                    db_cnt[i] <= '0;
                    level[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign sel_clr = press[2];
    assign sel_ss  = press[1] & ~press[2];
    assign sel_lap = press[0] & ~press[1] & ~press[2];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        clr_accept = 1'b0;
        case (state)
            IDLE: begin
                if (sel_clr)     clr_accept = 1'b1;
                else if (sel_ss) state_next = RUN;
            end
            RUN: begin
                if (sel_ss)       state_next = PAUSE;
                else if (sel_lap) state_next = LAP_RUN;
            end
            LAP_RUN: begin
                if (sel_ss)       state_next = PAUSE;
                else if (sel_lap) state_next = RUN;
            end
            PAUSE: begin
                if (sel_clr) begin
                    clr_accept = 1'b1;
                    state_next = IDLE;
                end else if (sel_ss) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Mode outputs follow state_next so they change on the same edge as state.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            cnt_enable <= 1'b0;
            cnt_reset  <= 1'b1;
            disp_load  <= 1'b1;
            running    <= 1'b0;
            lap_active <= 1'b0;
            rst_q      <= 1'b1;
        end else begin
            rst_q      <= 1'b0;
            cnt_reset  <= rst_q | clr_accept;
            disp_load  <= (state_next != LAP_RUN);
            running    <= (state_next == RUN) || (state_next == LAP_RUN);
            lap_active <= (state_next == LAP_RUN);
            cnt_enable <= 1'b0;
            if (clr_accept) begin
                prescaler <= '0;
            end else if ((state == RUN) || (state == LAP_RUN)) begin
                if (prescaler == PW'(TICK_DIV - 1)) begin
                    prescaler  <= '0;
                    cnt_enable <= ~rst_q;
                end else begin
                    prescaler <= prescaler + PW'(1);
                end
            end
        end
    end

endmodule
